// File: rtl/leitor_7seg.sv
// Two-digit seven-segment reader: waits for a stable {tens, units} segment pair
// and converts it back to a binary value 0-99, flagging illegal patterns.
module leitor_7seg #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_dez,
    input  logic [6:0] seg_uni,
    output logic [6:0] valor,
    output logic       valido,
    output logic       erro,
    output logic [7:0] n_leituras
);

    typedef enum logic {
        MEDINDO = 1'b0,
        ESTAVEL = 1'b1
    } estado_t;

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    // Returns {legal, digit}; blank_ok accepts an all-off digit as zero.
    function automatic logic [4:0] decode_digit(input logic [6:0] seg, input logic blank_ok);
        logic [4:0] res;
        case (seg)
            7'h40:   res = {1'b1, 4'd0};
            7'h79:   res = {1'b1, 4'd1};
            7'h24:   res = {1'b1, 4'd2};
            7'h30:   res = {1'b1, 4'd3};
            7'h19:   res = {1'b1, 4'd4};
            7'h12:   res = {1'b1, 4'd5};
            7'h02:   res = {1'b1, 4'd6};
            7'h78:   res = {1'b1, 4'd7};
            7'h00:   res = {1'b1, 4'd8};
            7'h10:   res = {1'b1, 4'd9};
            7'h7F:   res = blank_ok ? {1'b1, 4'd0} : {1'b0, 4'd0};
            default: res = {1'b0, 4'd0};
        endcase
        return res;
    endfunction

    estado_t     estado_q, estado_d;
    logic [13:0] amostra_q, amostra_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [6:0]  valor_q, valor_d;
    logic        valido_q, valido_d;
    logic        erro_q, erro_d;
    logic [7:0]  n_leituras_q, n_leituras_d;

    logic [13:0] entrada_s;
    logic [4:0]  dez_s;
    logic [4:0]  uni_s;
    logic [6:0]  valor_dec_s;

    assign entrada_s = {seg_dez, seg_uni};

    // Decode the stored sample, not the live input, so the report reflects the measured pair.
    always_comb begin
        dez_s       = decode_digit(amostra_q[13:7], 1'b1);
        uni_s       = decode_digit(amostra_q[6:0], 1'b0);
        valor_dec_s = ({3'd0, dez_s[3:0]} * 7'd10) + {3'd0, uni_s[3:0]};
    end

    // Next-state logic of the stability FSM and its report outputs.
    always_comb begin
        estado_d     = estado_q;
        amostra_d    = amostra_q;
        cnt_d        = cnt_q;
        valor_d      = valor_q;
        valido_d     = 1'b0;
        erro_d       = 1'b0;
        n_leituras_d = n_leituras_q;
        case (estado_q)
            MEDINDO: begin
                if (entrada_s != amostra_q) begin
                    amostra_d = entrada_s;
                    cnt_d     = 8'd0;
                end else if (cnt_q == CNT_LAST) begin
                    estado_d = ESTAVEL;
                    if (dez_s[4] && uni_s[4]) begin
                        valor_d      = valor_dec_s;
                        valido_d     = 1'b1;
                        n_leituras_d = n_leituras_q + 8'd1;
                    end else begin
                        erro_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ESTAVEL: begin
                if (entrada_s != amostra_q) begin
                    amostra_d = entrada_s;
                    cnt_d     = 8'd0;
                    estado_d  = MEDINDO;
                end else begin
                    estado_d = ESTAVEL;
                end
            end
            default: begin
                estado_d = ESTAVEL;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q     <= ESTAVEL;
            amostra_q    <= 14'h3FFF;
            cnt_q        <= 8'd0;
            valor_q      <= 7'd0;
            valido_q     <= 1'b0;
            erro_q       <= 1'b0;
            n_leituras_q <= 8'd0;
        end else begin
            estado_q     <= estado_d;
            amostra_q    <= amostra_d;
            cnt_q        <= cnt_d;
            valor_q      <= valor_d;
            valido_q     <= valido_d;
            erro_q       <= erro_d;
            n_leituras_q <= n_leituras_d;
        end
    end

    assign valor      = valor_q;
    assign valido     = valido_q;
    assign erro       = erro_q;
    assign n_leituras = n_leituras_q;

endmodule

// File: doc/leitor_7seg.md
# leitor_7seg

Two-digit seven-segment reader: the decoding end of the ALU's display path. It samples a tens/units pair of segment buses (the same encoding the ALU's digit displays drive), waits until the pair has been stable for a programmable number of clocks, and converts it back to a binary value 0–99. It is used as a loopback monitor in front of each ALU display pair (a, b, s) and as the input stage of the board self-check.

## Interface
- STABLE_CYCLES, default 4, required extra consecutive equal samples before a pair is reported; legal range 1–255.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- seg_dez  in  7  tens-digit segments, bit0=a … bit6=g, active-low.
- seg_uni  in  7  units-digit segments, same encoding.
- valor  out  7  last successfully decoded value, 0–99, binary.
- valido  out  1  one-cycle pulse: valor just updated.
- erro  out  1  one-cycle pulse: a stable pair contained an illegal pattern.
- n_leituras  out  8  count of valido pulses, wraps 255→0.

## Operation
- Legal digit patterns (active-low, hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
- Blank (7F) on seg_dez means tens = 0 (leading-zero suppression). Blank on seg_uni is illegal.
- Any other pattern on either digit is illegal.
- Decoded value = 10·tens + units, computed on 7 bits; cannot exceed 99.
- Internal registers: amostra (14-bit copy of {seg_dez, seg_uni}), cnt (8-bit stability counter), 2-state FSM.
- FSM MEDINDO: input ≠ amostra → amostra ← input, cnt ← 0, stay. Input = amostra and cnt < STABLE_CYCLES−1 → cnt+1. Input = amostra and cnt = STABLE_CYCLES−1 → report, go ESTAVEL.
- FSM ESTAVEL: input = amostra → hold, no pulses. Input ≠ amostra → amostra ← input, cnt ← 0, go MEDINDO.
- Report: both digits legal → valor ← decoded value, valido pulse, n_leituras + 1. Otherwise → erro pulse; valor and n_leituras unchanged.
- A given stable pair is reported exactly once. Re-reporting requires a change and a new stable period, even back to the same value.
- valido and erro are never high together.

## Timing
- Reset values: valor = 0, valido = 0, erro = 0, n_leituras = 0, amostra = {7F, 7F}, cnt = 0, FSM = ESTAVEL. A blank/blank input after reset therefore produces no erro.
- Latency: a pair first differing at edge t and held steady is reported at edge t+STABLE_CYCLES. valido/erro are high for the single cycle following that edge. The pair is sampled on STABLE_CYCLES+1 consecutive edges.
- Any change before the report edge restarts the count from that edge; no partial report is made.
- A change on the same edge the report would occur cancels the report; it restarts counting.
- A glitch of one cycle in ESTAVEL followed by a return to the old pair is a new measurement. The old pair is reported again after STABLE_CYCLES more edges.
- Reset asserted mid-measurement clears everything immediately, without waiting for a clock edge. Pulses already in flight are dropped. valor returns to 0.
- All outputs are registered; no combinational path from the seg inputs to any output.
- n_leituras increments on the same edge that raises valido.

## Test plan
- Reset, then hold seg_dez=24, seg_uni=12 (STABLE_CYCLES=4) → valido pulses exactly once, 4 edges after the first change; valor=25, n_leituras=1; no further pulses while held.
- Hold seg_dez=7F, seg_uni=30 → valor=3, valido once. Then seg_dez=7F, seg_uni=7F → erro once; valor stays 3.
- seg_uni=0F (illegal) with a legal tens digit → erro pulse; valor and n_leituras unchanged.
- Toggle seg_uni every 3 cycles between 79 and 24 → no valido and no erro. Stop toggling at 24 → one valido, 4 edges later.
- Stable 99 reported, 1-cycle glitch to 98, then back to 99 → no report for 98; 99 reported a second time; n_leituras increments by 1.
- Assert rst 2 cycles into a measurement of 42 → all outputs 0 immediately; after release with 42 still held, valido occurs only STABLE_CYCLES edges after the first post-reset edge.
- Run 256 distinct reports → n_leituras wraps to 0.
